// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration frame loader.
package cfg_loader_pkg;

    localparam int unsigned GEN_W   = 8;
    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SHIFT = 3'd1;
    localparam state_t ST_CHECK = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ERROR = 3'd4;

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Bitstream input handshake plus committed-configuration status bundle.
interface cfg_frame_loader_if
    import cfg_loader_pkg::*;
#(
    parameter int unsigned CFG_BITS = 64,
    parameter int unsigned CHUNK    = 4
);

    logic                start;
    logic                valid;
    logic [CHUNK-1:0]    data;
    logic [CFG_BITS-1:0] cfg;
    logic                busy;
    logic                done;
    logic                err;
    logic                fab_rst;
    logic [GEN_W-1:0]    gen;

    modport master (
        output start, valid, data,
        input  cfg, busy, done, err, fab_rst, gen
    );

    modport slave (
        input  start, valid, data,
        output cfg, busy, done, err, fab_rst, gen
    );

endinterface

// File: rtl/cfg_frame_loader.sv
// Loads a chunked frame into a shadow register, checks its XOR chunk and only
// then commits it to the live fabric configuration.
module cfg_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned CFG_BITS = 64,
    parameter int unsigned CHUNK    = 4
) (
    input  logic               clk,
    input  logic               rst,
    cfg_frame_loader_if.slave  bus
);

    localparam int unsigned NCHUNK = CFG_BITS / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if ((CFG_BITS % CHUNK) != 0) begin : g_bad_params
            $error("cfg_frame_loader: CFG_BITS must be a multiple of CHUNK");
        end
    endgenerate

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [CHUNK-1:0]    par_q,     par_d;
    logic [CFG_BITS-1:0] shadow_q,  shadow_d;
    logic [CFG_BITS-1:0] cfg_q,     cfg_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic                fab_rst_q, fab_rst_d;
    logic [GEN_W-1:0]    gen_q,     gen_d;

    // Next-state and output logic; start overrides everything, including valid.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        shadow_d  = shadow_q;
        cfg_d     = cfg_q;
        done_d    = done_q;
        err_d     = err_q;
        fab_rst_d = fab_rst_q;
        gen_d     = gen_q;

        if (bus.start) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            par_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (bus.valid) begin
                        // Truncating the concat keeps the first chunk heading toward the MSBs.
                        shadow_d = CFG_BITS'({shadow_q, bus.data});
                        par_d    = par_q ^ bus.data;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bus.valid) begin
                        if (bus.data == par_q) begin
                            cfg_d     = shadow_q;
                            done_d    = 1'b1;
                            fab_rst_d = 1'b0;
                            gen_d     = gen_q + GEN_W'(1);
                            state_d   = ST_DONE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_ERROR;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            par_q     <= '0;
            shadow_q  <= '0;
            cfg_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fab_rst_q <= 1'b1;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            shadow_q  <= shadow_d;
            cfg_q     <= cfg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fab_rst_q <= fab_rst_d;
            gen_q     <= gen_d;
        end
    end

    assign bus.cfg     = cfg_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.fab_rst = fab_rst_q;
    assign bus.gen     = gen_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Scoreboard bench for cfg_frame_loader at CFG_BITS=16, CHUNK=4.
module tb_cfg_frame_loader;

    localparam int unsigned CFG_BITS = 16;
    localparam int unsigned CHUNK    = 4;

    typedef struct {
        logic [15:0] cfg;
        logic        done;
        logic        err;
        logic        fab_rst;
        logic [7:0]  gen;
        int          due;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc_cnt;
    exp_t sb[$];

    logic [15:0] m_cfg;
    logic [7:0]  m_gen;
    logic        m_fab_rst;
    logic        prev_flag;
    logic        flag;

    cfg_frame_loader_if #(.CFG_BITS(CFG_BITS), .CHUNK(CHUNK)) bus ();

    cfg_frame_loader #(.CFG_BITS(CFG_BITS), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard monitor: on each rising done/err, pop the expected commit outcome.
    always @(negedge clk) begin
        flag = bus.done | bus.err;
        if (!rst && flag && !prev_flag) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: done=%0b err=%0b with no frame pending", bus.done, bus.err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.cfg, bus.done, bus.err, bus.fab_rst, bus.gen} !==
                    {e.cfg, e.done, e.err, e.fab_rst, e.gen}) begin
                    n_err++;
                    $display("FAIL sb_result: got cfg=%h done=%b err=%b fab_rst=%b gen=%0d, want cfg=%h done=%b err=%b fab_rst=%b gen=%0d",
                             bus.cfg, bus.done, bus.err, bus.fab_rst, bus.gen,
                             e.cfg, e.done, e.err, e.fab_rst, e.gen);
                end
                n_cmp++;
                if (cyc_cnt !== e.due) begin
                    n_err++;
                    $display("FAIL sb_latency: result at cycle %0d, want cycle %0d", cyc_cnt, e.due);
                end
            end
        end
        prev_flag = flag;
    end

    task automatic cyc(input logic s, input logic v, input logic [3:0] d);
        bus.start = s;
        bus.valid = v;
        bus.data  = d;
        @(negedge clk);
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        m_cfg     = 16'h0;
        m_gen     = 8'h0;
        m_fab_rst = 1'b1;
    endtask

    // Sends chunks MSB-first then the check chunk; expectation is queued as the check is driven.
    task automatic send_frame(input bit with_start, input logic [15:0] payload, input logic [3:0] chk);
        logic [3:0] par;
        logic [3:0] ch;
        exp_t       e;
        par = 4'h0;
        if (with_start) cyc(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            ch  = payload[15-4*i -: 4];
            par = par ^ ch;
            cyc(1'b0, 1'b1, ch);
        end
        if (chk == par) begin
            m_cfg     = payload;
            m_gen     = m_gen + 8'd1;
            m_fab_rst = 1'b0;
            e.done    = 1'b1;
            e.err     = 1'b0;
        end else begin
            e.done = 1'b0;
            e.err  = 1'b1;
        end
        e.cfg     = m_cfg;
        e.fab_rst = m_fab_rst;
        e.gen     = m_gen;
        e.due     = cyc_cnt + 1;
        sb.push_back(e);
        cyc(1'b0, 1'b1, chk);
        cyc(1'b0, 1'b0, 4'h0);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_timeout: %0d frame result(s) never reported", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.cfg !== 16'h0) begin n_err++; $display("FAIL reset_cfg: got %h want 0000", bus.cfg); end
        n_cmp++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags: busy/done/err got %b want 000", {bus.busy, bus.done, bus.err});
        end
        n_cmp++;
        if (bus.fab_rst !== 1'b1) begin n_err++; $display("FAIL reset_fab_rst: got %b want 1", bus.fab_rst); end
        n_cmp++;
        if (bus.gen !== 8'd0) begin n_err++; $display("FAIL reset_gen: got %0d want 0", bus.gen); end
    endtask

    task automatic test_good_frame();
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_pre_start: got %b want 0", bus.busy); end
        cyc(1'b1, 1'b0, 4'h0);
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_latency: got %b want 1 one cycle after start", bus.busy); end
        send_frame(1'b0, 16'h1234, 4'h4);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_after_commit: got %b want 0", bus.busy); end
        n_cmp++;
        if (bus.cfg !== 16'h1234) begin n_err++; $display("FAIL good_cfg: got %h want 1234", bus.cfg); end
    endtask

    task automatic test_valid_in_done();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'(9 + i));
        n_cmp++;
        if ({bus.cfg, bus.done, bus.err, bus.gen, bus.busy} !== {m_cfg, 1'b1, 1'b0, m_gen, 1'b0}) begin
            n_err++;
            $display("FAIL done_hold: got cfg=%h done=%b err=%b gen=%0d busy=%b want cfg=%h done=1 err=0 gen=%0d busy=0",
                     bus.cfg, bus.done, bus.err, bus.gen, bus.busy, m_cfg, m_gen);
        end
    endtask

    task automatic test_bad_frame();
        send_frame(1'b1, 16'hABCD, 4'h5);
        n_cmp++;
        if ({bus.cfg, bus.fab_rst, bus.gen} !== {16'h1234, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL bad_keeps_live: got cfg=%h fab_rst=%b gen=%0d want cfg=1234 fab_rst=0 gen=1",
                     bus.cfg, bus.fab_rst, bus.gen);
        end
        cyc(1'b0, 1'b1, 4'h0);
        n_cmp++;
        if ({bus.done, bus.err} !== 2'b01) begin
            n_err++; $display("FAIL err_hold: done/err got %b want 01", {bus.done, bus.err});
        end
    endtask

    task automatic test_gap_restart();
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h1);
        repeat (3) cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h2);
        repeat (2) cyc(1'b0, 1'b0, 4'h0);
        n_cmp++;
        if ({bus.busy, bus.err, bus.done} !== 3'b100) begin
            n_err++; $display("FAIL gap_busy: busy/err/done got %b want 100", {bus.busy, bus.err, bus.done});
        end
        cyc(1'b1, 1'b1, 4'hF);
        send_frame(1'b0, 16'h5678, 4'hC);
        n_cmp++;
        if (bus.cfg !== 16'h5678) begin n_err++; $display("FAIL restart_cfg: got %h want 5678", bus.cfg); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(1'b1, 16'h9E37, 4'h9 ^ 4'hE ^ 4'h3 ^ 4'h7);
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h6);
        cyc(1'b0, 1'b1, 4'h2);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        m_cfg     = 16'h0;
        m_gen     = 8'h0;
        m_fab_rst = 1'b1;
        n_cmp++;
        if ({bus.cfg, bus.fab_rst, bus.busy, bus.gen, bus.done} !== {16'h0, 1'b1, 1'b0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got cfg=%h fab_rst=%b busy=%b gen=%0d done=%b want cfg=0000 fab_rst=1 busy=0 gen=0 done=0",
                     bus.cfg, bus.fab_rst, bus.busy, bus.gen, bus.done);
        end
    endtask

    task automatic test_gen_wrap();
        logic [15:0] p;
        for (int f = 0; f < 256; f++) begin
            p = 16'($urandom);
            send_frame(1'b1, p, p[15:12] ^ p[11:8] ^ p[7:4] ^ p[3:0]);
        end
        n_cmp++;
        if ({bus.gen, bus.done, bus.err} !== {8'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL gen_wrap: got gen=%0d done=%b err=%b want gen=0 done=1 err=0", bus.gen, bus.done, bus.err);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        cyc_cnt   = 0;
        prev_flag = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 4'h0;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_valid_in_done();
        test_bad_frame();
        test_gap_restart();
        test_reset_mid_frame();
        test_gen_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
